// File: rtl/ff_pkg.sv
// Shared helpers for the ff_pipe delay line: log2 helper, derived port
// widths and the default reset value of the data stages.
package ff_pkg;

   // Default reset value for every data stage; the top truncates it to WIDTH.
   localparam logic [63:0] RST_VAL_DEF = 64'h0;

   // Ceiling log2; returns 0 for n <= 1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Tap select width: wide enough to address every stage, at least 1 bit.
   function automatic int tw_f(input int depth);
      return (clog2(depth) < 1) ? 1 : clog2(depth);
   endfunction

   // Occupancy width: must represent 0..depth inclusive.
   function automatic int ow_f(input int depth);
      return clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ff_stage.sv
// One enabled pipeline register carrying a data word and its valid bit.
// clr drops the valid bit regardless of en; data still follows en.
module ff_stage
   import ff_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(RST_VAL_DEF)
) (
   input  logic             ck,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   input  logic             d_vld,
   output logic [WIDTH-1:0] q,
   output logic             q_vld
);

   logic [WIDTH-1:0] data_d, data_q;
   logic             vld_d,  vld_q;

   // Next state: load on en, otherwise hold; clr wins for the valid bit only.
   always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      if (en) begin
         data_d = d;
         vld_d  = d_vld;
      end
      if (clr) vld_d = 1'b0;
   end

   // State register with asynchronous reset to RST_VAL / invalid.
   always_ff @(posedge ck or posedge rst) begin
      // NOTE: non-blocking assignments here so every stage samples its
      // neighbour's old value on the same edge; blocking would collapse the chain.
      if (rst) begin
         data_q <= RST_VAL;
         vld_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         vld_q  <= vld_d;
      end
   end

   assign q     = data_q;
   assign q_vld = vld_q;

endmodule

// File: rtl/ff_pipe.sv
// WIDTH-bit, DEPTH-stage enable-gated delay line with per-stage valid bits,
// synchronous flush and an incrementally maintained occupancy count.
// Build option FF_PIPE_TAP_EN: adds the tap port and a clamped output mux;
// without it the output is the last stage.
module ff_pipe
   import ff_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter int               DEPTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(RST_VAL_DEF)
) (
   input  logic                       ck,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           d,
   input  logic                       d_vld,
`ifdef FF_PIPE_TAP_EN
   input  logic [tw_f(DEPTH)-1:0]     tap,
`endif
   output logic [WIDTH-1:0]           q,
   output logic                       q_vld,
   output logic                       busy,
   output logic [ow_f(DEPTH)-1:0]     occ
);

   localparam int TW = tw_f(DEPTH);
   localparam int OW = ow_f(DEPTH);

   logic [WIDTH-1:0] s_data [DEPTH];
   logic [DEPTH-1:0] s_vld;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic [WIDTH-1:0] in_data;
      logic             in_vld;
      if (k == 0) begin : g_head
         assign in_data = d;
         assign in_vld  = d_vld;
      end else begin : g_body
         assign in_data = s_data[k-1];
         assign in_vld  = s_vld[k-1];
      end
      ff_stage #(
         .WIDTH   (WIDTH),
         .RST_VAL (RST_VAL)
      ) u_stage (
         .ck    (ck),
         .rst   (rst),
         .en    (en),
         .clr   (flush),
         .d     (in_data),
         .d_vld (in_vld),
         .q     (s_data[k]),
         .q_vld (s_vld[k])
      );
   end

   logic [OW-1:0] occ_d, occ_q;

   // Occupancy: +1 for a valid word entering, -1 for one falling off the end.
   // Modulo-OW arithmetic is exact because the true result stays in 0..DEPTH.
   always_comb begin
      occ_d = occ_q;
      if (flush)   occ_d = '0;
      else if (en) occ_d = occ_q + OW'(d_vld) - OW'(s_vld[DEPTH-1]);
   end

   // Occupancy register, cleared together with the stages on reset.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) occ_q <= '0;
      else     occ_q <= occ_d;
   end

   assign occ  = occ_q;
   assign busy = (occ_q != '0);

`ifdef FF_PIPE_TAP_EN
   localparam logic [TW:0]   DEPTH_W = (TW+1)'(DEPTH);
   localparam logic [TW-1:0] LAST    = TW'(DEPTH - 1);

   logic [TW-1:0] sel;

   // Output select: tap values past the last stage clamp to the last stage.
   always_comb begin
      sel = tap;
      if ({1'b0, tap} >= DEPTH_W) sel = LAST;
   end

   assign q     = s_data[sel];
   assign q_vld = s_vld[sel];
`else
   assign q     = s_data[DEPTH-1];
   assign q_vld = s_vld[DEPTH-1];
`endif

endmodule
